// File: rtl/cache_axi_bridge.sv
// Data-cache to AXI4 master bridge: one outstanding line refill/single read and one outstanding
// write-back/single write. Optional macro AXI_RESP_CHECK_EN enables the sticky axi_err response/ID check.
module cache_axi_bridge #(
    parameter int              ID_W  = 4,
    parameter logic [ID_W-1:0] RD_ID = 4'd0,
    parameter logic [ID_W-1:0] WR_ID = 4'd1
) (
    input  logic              clk,
    input  logic              resetn,
    // cache read side
    input  logic              rd_req,
    input  logic [2:0]        rd_type,
    input  logic [31:0]       rd_addr,
    output logic              rd_rdy,
    output logic              ret_valid,
    output logic              ret_last,
    output logic [31:0]       ret_data,
    // cache write side
    input  logic              wr_req,
    input  logic [2:0]        wr_type,
    input  logic [31:0]       wr_addr,
    input  logic [3:0]        wr_wstrb,
    input  logic [127:0]      wr_data,
    output logic              wr_rdy,
    // AXI read address
    output logic [ID_W-1:0]   arid,
    output logic [31:0]       araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    // AXI read data
    input  logic [ID_W-1:0]   rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // AXI write address
    output logic [ID_W-1:0]   awid,
    output logic [31:0]       awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    // AXI write data
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    // AXI write response
    input  logic [ID_W-1:0]   bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic              axi_err
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;

    localparam logic [2:0] TYPE_LINE   = 3'b100;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    function automatic logic [7:0] f_len(input logic [2:0] t);
        return (t == TYPE_LINE) ? 8'd3 : 8'd0;
    endfunction

    function automatic logic [2:0] f_size(input logic [2:0] t);
        return (t == TYPE_LINE) ? 3'b010 : {1'b0, t[1:0]};
    endfunction

    rd_state_t     r_rd_state, w_rd_state_next;
    wr_state_t     r_wr_state, w_wr_state_next;

    logic [31:0]   r_rd_addr;
    logic [2:0]    r_rd_type;
    logic [31:0]   r_wr_addr;
    logic [2:0]    r_wr_type;
    logic [3:0]    r_wr_strb;
    logic [127:0]  r_wr_data;
    logic [1:0]    r_beat_cnt;

    logic          w_hazard;
    logic          w_wlast;
    logic [7:0]    w_wr_len;
    logic [31:0]   w_wr_word [4];

    // A read may not pass a write-back to the same line, including one being accepted this cycle.
    assign w_hazard = ((r_wr_state != W_IDLE) && (rd_addr[31:4] == r_wr_addr[31:4])) ||
                      ((r_wr_state == W_IDLE) && wr_req && (rd_addr[31:4] == wr_addr[31:4]));

    // ---------------- read path ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_state <= R_IDLE;
            r_rd_addr  <= '0;
            r_rd_type  <= '0;
        end else begin
            r_rd_state <= w_rd_state_next;
            if (rd_req && rd_rdy) begin
                r_rd_addr <= rd_addr;
                r_rd_type <= rd_type;
            end
        end
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        rd_rdy          = 1'b0;
        arvalid         = 1'b0;
        rready          = 1'b0;
        ret_valid       = 1'b0;
        ret_last        = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                rd_rdy = ~w_hazard;
                if (rd_req && !w_hazard) w_rd_state_next = R_AR;
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) w_rd_state_next = R_DATA;
            end
            R_DATA: begin
                rready    = 1'b1;
                ret_valid = rvalid;
                ret_last  = rvalid & rlast;
                if (rvalid && rlast) w_rd_state_next = R_IDLE;
            end
            default: w_rd_state_next = R_IDLE;
        endcase
    end

    assign ret_data = rdata;
    assign arid     = RD_ID;
    assign araddr   = r_rd_addr;
    assign arlen    = f_len(r_rd_type);
    assign arsize   = f_size(r_rd_type);
    assign arburst  = BURST_INCR;

    // ---------------- write path ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_state <= W_IDLE;
            r_wr_addr  <= '0;
            r_wr_type  <= '0;
            r_wr_strb  <= '0;
            r_wr_data  <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_wr_state <= w_wr_state_next;
            if (r_wr_state == W_IDLE && wr_req) begin
                r_wr_addr  <= wr_addr;
                r_wr_type  <= wr_type;
                r_wr_strb  <= wr_wstrb;
                r_wr_data  <= wr_data;
                r_beat_cnt <= '0;
            end else if (r_wr_state == W_DATA && wready) begin
                r_beat_cnt <= r_beat_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        w_wr_state_next = r_wr_state;
        wr_rdy          = 1'b0;
        awvalid         = 1'b0;
        wvalid          = 1'b0;
        bready          = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                wr_rdy = 1'b1;
                if (wr_req) w_wr_state_next = W_AW;
            end
            W_AW: begin
                awvalid = 1'b1;
                if (awready) w_wr_state_next = W_DATA;
            end
            W_DATA: begin
                wvalid = 1'b1;
                if (wready && w_wlast) w_wr_state_next = W_RESP;
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) w_wr_state_next = W_IDLE;
            end
            default: w_wr_state_next = W_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            assign w_wr_word[gi] = r_wr_data[32*gi +: 32];
        end
    endgenerate

    assign w_wr_len = f_len(r_wr_type);
    assign w_wlast  = ({6'd0, r_beat_cnt} == w_wr_len);

    assign awid    = WR_ID;
    assign awaddr  = r_wr_addr;
    assign awlen   = w_wr_len;
    assign awsize  = f_size(r_wr_type);
    assign awburst = BURST_INCR;
    assign wdata   = w_wr_word[r_beat_cnt];
    assign wstrb   = (r_wr_type == TYPE_LINE) ? 4'hF : r_wr_strb;
    assign wlast   = w_wlast;

    // ---------------- response checking ----------------
`ifdef AXI_RESP_CHECK_EN
    logic r_axi_err;
    logic w_r_bad;
    logic w_b_bad;

    assign w_r_bad = rvalid & rready & ((rresp != 2'b00) | (rid != RD_ID));
    assign w_b_bad = bvalid & bready & ((bresp != 2'b00) | (bid != WR_ID));

    always_ff @(posedge clk) begin
        if (!resetn)                r_axi_err <= 1'b0;
        else if (w_r_bad | w_b_bad) r_axi_err <= 1'b1;
    end

    assign axi_err = r_axi_err;
`else
    logic w_unused_resp;
    assign w_unused_resp = ^{rresp, bresp, rid, bid};
    assign axi_err       = 1'b0;
`endif

endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Sits directly downstream of the data cache. Converts the cache miss-refill read requests (rd_*/ret_*) and dirty-line write-back requests (wr_*) into AXI4 master transactions.
- Holds one outstanding read and one outstanding write.
- Blocks a read whose line address matches a write-back that is still pending, so a refill never overtakes its own victim's write-back.

Parameters:
- RD_ID, 4'd0, ARID driven on every read.
- WR_ID, 4'd1, AWID driven on every write.
- ID_W, 4, width of all AXI ID fields.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- rd_req  in  1  cache read request, held until accepted
- rd_type  in  3  3'b100 = 4-word line; 3'b000/001/010 = single byte/half/word
- rd_addr  in  32  read byte address
- rd_rdy  out  1  read request accepted this cycle when rd_req & rd_rdy
- ret_valid  out  1  read data beat valid
- ret_last  out  1  last beat of a read
- ret_data  out  32  read data beat
- wr_req  in  1  write request, accepted when wr_req & wr_rdy
- wr_type  in  3  same encoding as rd_type
- wr_addr  in  32  write byte address
- wr_wstrb  in  4  byte strobe, used for single-beat writes only
- wr_data  in  128  line data; word n = bits [32n+31:32n]
- wr_rdy  out  1  write buffer free
- arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/32/8/3/2/1  AXI read address channel
- arready  in  1  AXI read address channel
- rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1  AXI read data channel
- rready  out  1  AXI read data channel
- awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_W/32/8/3/2/1  AXI write address channel
- awready  in  1  AXI write address channel
- wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI write data channel
- wready  in  1  AXI write data channel
- bid/bresp/bvalid  in  ID_W/2/1  AXI write response channel
- bready  out  1  AXI write response channel
- axi_err  out  1  sticky error flag (feature-dependent)

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk.
  - At reset: all *valid, rready, bready, ret_valid, axi_err = 0; rd_rdy = 1, wr_rdy = 1; both FSMs idle; beat counter = 0.
  - Reset mid-burst abandons the transaction; no recovery of AXI state is required.
- Type decode:
  - 3'b100 → len = 3, size = 3'b010, burst = INCR (2'b01).
  - Otherwise → len = 0, size = {1'b0, type[1:0]}, burst = INCR.
  - Address is passed unmodified.
- Read FSM (R_IDLE, R_AR, R_DATA):
  - R_IDLE: rd_rdy = ~hazard. On rd_req & rd_rdy, latch addr/type and go to R_AR.
  - R_AR: arvalid = 1, fields come from the latch. On arready, go to R_DATA.
  - R_DATA: rready = 1. ret_valid = rvalid, ret_data = rdata, ret_last = rlast, all combinational, same cycle. On rvalid & rlast, go to R_IDLE.
  - rd_rdy = 0 in R_AR and R_DATA.
  - First ret beat is no earlier than 2 cycles after acceptance.
- Write FSM (W_IDLE, W_AW, W_DATA, W_RESP):
  - W_IDLE: wr_rdy = 1. On wr_req, latch addr/type/wstrb/128-bit data, clear beat counter, go to W_AW.
  - W_AW: awvalid = 1. On awready, go to W_DATA.
  - W_DATA: wvalid = 1; wdata = word[cnt]; wstrb = 4'hF for line writes, latched wstrb for single writes.
    - wlast = (cnt == len).
    - On wready: cnt++. If wlast, go to W_RESP.
  - W_RESP: bready = 1. On bvalid, go to W_IDLE.
  - wr_rdy = 0 outside W_IDLE.
  - AW always precedes W; there is no W-before-AW.
- Hazard: hazard = (w_state != W_IDLE) & (rd_addr[31:4] == latched wr_addr[31:4]).
  - rd_rdy stays low until the cycle after bvalid is accepted.
  - A wr_req and rd_req to the same line in the same idle cycle: the write is accepted; the read is blocked from the next cycle. In that same cycle the hazard is computed with w_state == W_IDLE, so it must also compare against wr_addr when wr_req & wr_rdy.
- Independence: the read and write FSMs run concurrently; AR and AW may be valid in the same cycle.
- Protocol: valid signals never drop before handshake; latched fields are stable while valid.

Optional Feature:
- Macro AXI_RESP_CHECK_EN.
- Defined:
  - axi_err is set on (rvalid & rready & rresp != 0) or (bvalid & bready & bresp != 0). It stays set until reset.
  - rid/bid not matching RD_ID/WR_ID also sets axi_err.
- Undefined: axi_err is tied 0; rresp, bresp, rid, bid are ignored.

Test Plan:
- Line read: rd_req, type 100, addr 0x1C000040; arready after 1 cycle; rdata 0xA0..0xA3 with rlast on beat 3.
  → araddr = 0x1C000040, arlen = 3, arsize = 2; ret_data A0–A3; ret_last only with A3; rd_rdy back to 1 the next cycle.
- Line write-back: wr_req, addr 0x00001230, data {D3,D2,D1,D0}; wready stalls 2 cycles on beat 1.
  → awlen = 3; wdata order D0,D1,D2,D3; wstrb F; wlast only on D3; wr_rdy = 1 after bvalid.
- Single write: type 010, wstrb 4'b0011, addr 0xBFAF0000.
  → awlen = 0, awsize = 2; one beat carrying word[0] with wstrb 0011 and wlast = 1.
- Hazard: write-back to 0x80, then rd_req to 0x84 while bvalid is withheld 5 cycles.
  → rd_rdy = 0 and no arvalid until after bvalid; a read to 0x90 during the same window is accepted immediately.
- Concurrency: read and write accepted in the same cycle to different lines.
  → arvalid and awvalid both high in the next cycle; both complete independently.
- AXI_RESP_CHECK_EN defined, bresp = 2'b10.
  → axi_err = 1 the cycle after the B handshake and stays 1. Undefined → axi_err stays 0.
